// File: rtl/sv_stream_fifo.sv
// Parametrised synchronous FIFO with valid/ready handshakes on both sides.
// The head word is read straight out of storage, so there is no path from in_data to out_data.
module sv_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AFULL = 3,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  bit             clk,
  input  bit             rst,
  input  bit             flush,
  input  bit [WIDTH-1:0] in_data,
  input  bit             in_valid,
  output bit             in_ready,
  output bit [WIDTH-1:0] out_data,
  output bit             out_valid,
  input  bit             out_ready,
  output bit [CW-1:0]    count,
  output bit             almost_full
);

  localparam int PW = $clog2(DEPTH);

  bit [WIDTH-1:0] mem [DEPTH];
  bit [PW-1:0]    wr_ptr;
  bit [PW-1:0]    rd_ptr;
  bit             push;
  bit             pop;

  // Status comes only from registered state, so a pop never frees a slot for a push in the same cycle.
  assign in_ready    = (count != CW'(DEPTH));
  assign out_valid   = (count != '0);
  assign almost_full = (count >= CW'(AFULL));
  assign out_data    = mem[rd_ptr];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are exactly PW bits wide, so DEPTH-1 wraps to 0 by truncation.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // NOTE: the storage array is deliberately left out of reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_sv_stream_fifo.sv
// Directed self-checking bench for sv_stream_fifo (WIDTH=8, DEPTH=4, AFULL=3).
// Inputs change 1ns after each rising edge, and outputs are sampled at that point as well.
module tb_sv_stream_fifo;

  bit       clk;
  bit       rst;
  bit       flush;
  bit [7:0] in_data;
  bit       in_valid;
  bit       in_ready;
  bit [7:0] out_data;
  bit       out_valid;
  bit       out_ready;
  bit [2:0] count;
  bit       almost_full;

  int n_checks = 0;
  int n_errors = 0;

  sv_stream_fifo #(.WIDTH(8), .DEPTH(4), .AFULL(3)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count(count),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic push_word(input bit [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    check("reset_count", count, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_almost_full", almost_full, 0);
    rst = 1'b0;

    // Ordering, no bypass while empty
    in_valid = 1'b1;
    in_data  = 8'h11;
    check("no_bypass_out_valid", out_valid, 0);
    tick();
    check("first_word_valid", out_valid, 1);
    check("first_word_data", out_data, 8'h11);
    in_data = 8'h22;
    tick();
    check("afull_below_threshold", almost_full, 0);
    in_data = 8'h33;
    tick();
    in_valid = 1'b0;
    check("order_count", count, 3);
    check("order_almost_full", almost_full, 1);
    check("order_head", out_data, 8'h11);
    out_ready = 1'b1;
    check("order_pop0", out_data, 8'h11);
    tick();
    check("order_pop1", out_data, 8'h22);
    tick();
    check("order_pop2", out_data, 8'h33);
    tick();
    check("order_empty_valid", out_valid, 0);
    check("order_empty_count", count, 0);
    out_ready = 1'b0;

    // Full, dropped push, wrap
    for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    push_word(8'hFF);
    check("full_drop_count", count, 4);
    check("full_drop_head", out_data, 8'hA0);
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("full_pop_no_push_count", count, 3);
    check("full_pop_head", out_data, 8'hA1);
    tick();
    out_ready = 1'b0;
    check("pop2_count", count, 2);
    push_word(8'hB0);
    push_word(8'hB1);
    check("wrap_count", count, 4);
    out_ready = 1'b1;
    check("wrap_drain0", out_data, 8'hA2);
    tick();
    check("wrap_drain1", out_data, 8'hA3);
    tick();
    check("wrap_drain2", out_data, 8'hB0);
    tick();
    check("wrap_drain3", out_data, 8'hB1);
    tick();
    check("wrap_empty", out_valid, 0);
    out_ready = 1'b0;

    // Simultaneous push and pop at count 2
    push_word(8'h44);
    push_word(8'h45);
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("simul_count", count, 2);
    check("simul_head", out_data, 8'h45);
    tick();
    check("simul_next", out_data, 8'h55);
    tick();
    check("simul_empty", count, 0);

    // Push into empty while out_ready is high
    in_valid = 1'b1;
    in_data  = 8'h66;
    check("empty_push_valid_low", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("empty_push_count", count, 1);
    check("empty_push_data", out_data, 8'h66);
    tick();
    check("empty_push_drained", count, 0);
    out_ready = 1'b0;

    // Flush overrides push and pop
    push_word(8'h01);
    push_word(8'h02);
    push_word(8'h03);
    check("pre_flush_count", count, 3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("flush_count", count, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    push_word(8'h88);
    check("post_flush_count", count, 1);
    check("post_flush_data", out_data, 8'h88);

    // Reset mid-stream overrides flush
    push_word(8'h89);
    push_word(8'h8A);
    push_word(8'h8B);
    check("pre_reset_count", count, 4);
    rst      = 1'b1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hCC;
    tick();
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("midreset_count", count, 0);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_almost_full", almost_full, 0);
    push_word(8'hD0);
    check("post_reset_data", out_data, 8'hD0);
    check("post_reset_count", count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
